// File: rtl/dm_cache_pkg.sv
// Shared types for the direct-mapped cache: controller states, request modes
// and the per-line record (geometry fixed by the default cache parameters).
package dm_cache_pkg;

  localparam int CACHE_ADDR_W  = 32;
  localparam int CACHE_DATA_W  = 32;
  localparam int CACHE_INDEX_W = 12;
  localparam int CACHE_TAG_W   = CACHE_ADDR_W - CACHE_INDEX_W;

  localparam logic MODE_READ  = 1'b0;
  localparam logic MODE_WRITE = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_COMPARE,
    ST_WB,
    ST_FILL_REQ,
    ST_FILL_WAIT,
    ST_RESP
  } state_e;

  typedef struct packed {
    logic                    valid;
    logic                    dirty;
    logic [CACHE_TAG_W-1:0]  tag;
    logic [CACHE_DATA_W-1:0] data;
  } line_t;

endpackage

// File: rtl/dm_cache_if.sv
// Requester and backing-memory handshake bundle; the cache uses the slave view,
// the environment (requester plus memory) uses the master view.
interface dm_cache_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) ();
  logic              req_valid;
  logic              req_ready;
  logic              req_mode;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_data;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_hit;
  logic              mem_req_valid;
  logic              mem_req_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_rsp_valid;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  req_valid, req_mode, req_addr, req_data,
    input  mem_req_ready, mem_rsp_valid, mem_rdata,
    output req_ready, rsp_valid, rsp_data, rsp_hit,
    output mem_req_valid, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output req_valid, req_mode, req_addr, req_data,
    output mem_req_ready, mem_rsp_valid, mem_rdata,
    input  req_ready, rsp_valid, rsp_data, rsp_hit,
    input  mem_req_valid, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/dm_cache_store.sv
// Line array: combinational read, synchronous write. Only valid/dirty carry a
// reset so the whole array is invalidated in one cycle; tag/data are plain RAM.
module dm_cache_store
  import dm_cache_pkg::*;
#(
  parameter int INDEX_W = CACHE_INDEX_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [INDEX_W-1:0] rd_idx_i,
  output line_t              rd_line_o,
  input  logic               we_i,
  input  logic [INDEX_W-1:0] wr_idx_i,
  input  line_t              wr_line_i
);
  localparam int LINES = 1 << INDEX_W;

  logic [LINES-1:0]        valid_q;
  logic [LINES-1:0]        dirty_q;
  logic [CACHE_TAG_W-1:0]  tag_q  [LINES];
  logic [CACHE_DATA_W-1:0] data_q [LINES];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (we_i) begin
      valid_q[wr_idx_i] <= wr_line_i.valid;
      dirty_q[wr_idx_i] <= wr_line_i.dirty;
    end
  end

  always_ff @(posedge clk) begin
    if (we_i) begin
      tag_q[wr_idx_i]  <= wr_line_i.tag;
      data_q[wr_idx_i] <= wr_line_i.data;
    end
  end

  always_comb begin
    rd_line_o.valid = valid_q[rd_idx_i];
    rd_line_o.dirty = dirty_q[rd_idx_i];
    rd_line_o.tag   = tag_q[rd_idx_i];
    rd_line_o.data  = data_q[rd_idx_i];
  end

endmodule

// File: rtl/dm_cache.sv
// Direct-mapped write-back / write-allocate cache controller with one
// outstanding request and saturating hit/miss statistics.
module dm_cache
  import dm_cache_pkg::*;
#(
  parameter int ADDR_W  = CACHE_ADDR_W,
  parameter int DATA_W  = CACHE_DATA_W,
  parameter int INDEX_W = CACHE_INDEX_W,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  dm_cache_if.slave        bus,
  output logic [CNT_W-1:0] hit_count,
  output logic [CNT_W-1:0] miss_count
);
  localparam int TAG_W = ADDR_W - INDEX_W;

  state_e              state_q, state_d;
  logic                mode_q, mode_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;
  logic                rsp_hit_q, rsp_hit_d;
  logic [CNT_W-1:0]    hit_cnt_q, hit_cnt_d;
  logic [CNT_W-1:0]    miss_cnt_q, miss_cnt_d;

  logic [INDEX_W-1:0]  idx;
  logic [TAG_W-1:0]    tag;
  line_t               line_rd;
  line_t               line_wr;
  logic                line_we;
  logic                hit;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  assign idx = addr_q[INDEX_W-1:0];
  assign tag = addr_q[ADDR_W-1:INDEX_W];
  assign hit = line_rd.valid && (line_rd.tag == tag);

  dm_cache_store #(.INDEX_W(INDEX_W)) u_store (
    .clk       (clk),
    .rst_n     (rst_n),
    .rd_idx_i  (idx),
    .rd_line_o (line_rd),
    .we_i      (line_we),
    .wr_idx_i  (idx),
    .wr_line_i (line_wr)
  );

  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rsp_data_d = rsp_data_q;
    rsp_hit_d  = rsp_hit_q;
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    // Default line image is a dirty install of the latched write data.
    line_we       = 1'b0;
    line_wr.valid = 1'b1;
    line_wr.dirty = 1'b1;
    line_wr.tag   = tag;
    line_wr.data  = wdata_q;
    bus.req_ready     = 1'b0;
    bus.rsp_valid     = 1'b0;
    bus.mem_req_valid = 1'b0;
    bus.mem_we        = 1'b0;
    bus.mem_addr      = '0;
    bus.mem_wdata     = '0;

    unique case (state_q)
      ST_IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) begin
          mode_d  = bus.req_mode;
          addr_d  = bus.req_addr;
          wdata_d = bus.req_data;
          state_d = ST_COMPARE;
        end
      end
      ST_COMPARE: begin
        rsp_hit_d = hit;
        if (hit) hit_cnt_d = sat_inc(hit_cnt_q);
        else     miss_cnt_d = sat_inc(miss_cnt_q);
        if (hit) begin
          if (mode_q == MODE_WRITE) begin
            line_we    = 1'b1;
            rsp_data_d = wdata_q;
          end else begin
            rsp_data_d = line_rd.data;
          end
          state_d = ST_RESP;
        end else if (line_rd.valid && line_rd.dirty) begin
          state_d = ST_WB;
        end else if (mode_q == MODE_WRITE) begin
          line_we    = 1'b1;
          rsp_data_d = wdata_q;
          state_d    = ST_RESP;
        end else begin
          state_d = ST_FILL_REQ;
        end
      end
      ST_WB: begin
        bus.mem_req_valid = 1'b1;
        bus.mem_we        = 1'b1;
        bus.mem_addr      = {line_rd.tag, idx};
        bus.mem_wdata     = line_rd.data;
        if (bus.mem_req_ready) begin
          if (mode_q == MODE_WRITE) begin
            line_we    = 1'b1;
            rsp_data_d = wdata_q;
            state_d    = ST_RESP;
          end else begin
            state_d = ST_FILL_REQ;
          end
        end
      end
      ST_FILL_REQ: begin
        bus.mem_req_valid = 1'b1;
        bus.mem_addr      = addr_q;
        if (bus.mem_req_ready) state_d = ST_FILL_WAIT;
      end
      ST_FILL_WAIT: begin
        if (bus.mem_rsp_valid) begin
          line_we       = 1'b1;
          line_wr.dirty = 1'b0;
          line_wr.data  = bus.mem_rdata;
          rsp_data_d    = bus.mem_rdata;
          state_d       = ST_RESP;
        end
      end
      ST_RESP: begin
        bus.rsp_valid = 1'b1;
        state_d       = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      rsp_data_q <= '0;
      rsp_hit_q  <= 1'b0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      rsp_data_q <= rsp_data_d;
      rsp_hit_q  <= rsp_hit_d;
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  // Request latch is pure data; its contents are only meaningful after IDLE.
  always_ff @(posedge clk) begin
    mode_q  <= mode_d;
    addr_q  <= addr_d;
    wdata_q <= wdata_d;
  end

  assign bus.rsp_data = rsp_data_q;
  assign bus.rsp_hit  = rsp_hit_q;
  assign hit_count    = hit_cnt_q;
  assign miss_count   = miss_cnt_q;

endmodule
